// File: rtl/hazard_pkg.sv
// hazard_pkg: shared state, forward-select and result-source definitions
package hazard_pkg;
    typedef enum logic {RUN, MWAIT} state_t;
    typedef enum logic [1:0] {FWD_RF = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10} fwd_sel_t;
    localparam logic [1:0] RSLT_MEM = 2'b01;
endpackage

// File: rtl/fwd_unit.sv
// fwd_unit: execute operand bypass select for one source register
module fwd_unit
    import hazard_pkg::*;
(
    input  logic [4:0] rs_i,
    input  logic       reg_wrt_m_i,
    input  logic [4:0] rd_m_i,
    input  logic       reg_wrt_w_i,
    input  logic [4:0] rd_w_i,
    output fwd_sel_t   fwd_o
);
    logic hit_m;
    logic hit_w;
    assign hit_m = reg_wrt_m_i && rd_m_i != 5'd0 && rd_m_i == rs_i;
    assign hit_w = reg_wrt_w_i && rd_w_i != 5'd0 && rd_w_i == rs_i;
    assign fwd_o = hit_m ? FWD_MEM : hit_w ? FWD_WB : FWD_RF;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall/flush/forward control with data-memory wait timeout; forwarding enabled by FWD_EN
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] rs1d,
    input  logic [4:0] rs2d,
    input  logic [4:0] rs1e,
    input  logic [4:0] rs2e,
    input  logic [4:0] rde,
    input  logic       regWrte,
    input  logic       regWrtm,
    input  logic       regWrtw,
    input  logic [1:0] rsltSrce,
    input  logic [4:0] rdm,
    input  logic [4:0] rdw,
    input  logic       pcSrce,
    input  logic       memReqm,
    input  logic       memRdym,
    output logic       stallf,
    output logic       stalld,
    output logic       stalle,
    output logic       stallm,
    output logic       flushd,
    output logic       flushe,
    output logic       flushw,
    output logic [1:0] fwdAe,
    output logic [1:0] fwdBe,
    output logic       memTmo
);
    localparam logic [7:0] MAX_CNT = 8'(MAX_WAIT);
    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       mem_stall;
    logic       tmo;
    logic       lu;
    logic       br;
    logic       hz;
    fwd_sel_t   fwd_a;
    fwd_sel_t   fwd_b;
    fwd_unit u_fwd_a (
        .rs_i        (rs1e),
        .reg_wrt_m_i (regWrtm),
        .rd_m_i      (rdm),
        .reg_wrt_w_i (regWrtw),
        .rd_w_i      (rdw),
        .fwd_o       (fwd_a)
    );
    fwd_unit u_fwd_b (
        .rs_i        (rs2e),
        .reg_wrt_m_i (regWrtm),
        .rd_m_i      (rdm),
        .reg_wrt_w_i (regWrtw),
        .rd_w_i      (rdw),
        .fwd_o       (fwd_b)
    );
`ifdef FWD_EN
    assign lu    = regWrte && rsltSrce == RSLT_MEM && rde != 5'd0 && (rde == rs1d || rde == rs2d);
    assign fwdAe = rst ? FWD_RF : fwd_a;
    assign fwdBe = rst ? FWD_RF : fwd_b;
`else
    logic unused_fwd;
    assign unused_fwd = ^{rsltSrce, fwd_a, fwd_b};
    assign lu = (rs1d != 5'd0 && ((regWrte && rs1d == rde) || (regWrtm && rs1d == rdm))) ||
                (rs2d != 5'd0 && ((regWrte && rs2d == rde) || (regWrtm && rs2d == rdm)));
    assign fwdAe = FWD_RF;
    assign fwdBe = FWD_RF;
`endif
    // Memory wait FSM: next state, wait counter, stall and timeout detection
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mem_stall = 1'b0;
        tmo       = 1'b0;
        if (state_q == RUN) begin
            mem_stall = memReqm && !memRdym;
            state_d   = mem_stall ? MWAIT : RUN;
            cnt_d     = mem_stall ? 8'd1 : 8'd0;
        end else if (memRdym) begin
            state_d = RUN;
            cnt_d   = 8'd0;
        end else if (cnt_q >= MAX_CNT) begin
            tmo     = 1'b1;
            state_d = RUN;
            cnt_d   = 8'd0;
        end else begin
            mem_stall = 1'b1;
            cnt_d     = cnt_q + 8'd1;
        end
    end
    // A memory stall masks branch and load-use; a branch overrides the load-use stall
    assign br     = pcSrce && !mem_stall;
    assign hz     = lu && !mem_stall && !br;
    assign stallf = !rst && (mem_stall || hz);
    assign stalld = !rst && (mem_stall || hz);
    assign stalle = !rst && mem_stall;
    assign stallm = !rst && mem_stall;
    assign flushd = rst || br;
    assign flushe = rst || br || hz;
    assign flushw = rst || mem_stall || tmo;
    assign memTmo = !rst && tmo;
    // State and wait counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: table vectors plus memory-wait/reset sequences checked through an expected-value queue
module tb_hazard_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic       regWrte, regWrtm, regWrtw, pcSrce, memReqm, memRdym;
    logic [1:0] rsltSrce;
    logic       stallf, stalld, stalle, stallm, flushd, flushe, flushw, memTmo;
    logic [1:0] fwdAe, fwdBe;

    always #5 clk = ~clk;

    hazard_ctrl #(.MAX_WAIT(4)) dut (
        .clk(clk), .rst(rst),
        .rs1d(rs1d), .rs2d(rs2d), .rs1e(rs1e), .rs2e(rs2e), .rde(rde),
        .regWrte(regWrte), .regWrtm(regWrtm), .regWrtw(regWrtw),
        .rsltSrce(rsltSrce), .rdm(rdm), .rdw(rdw), .pcSrce(pcSrce),
        .memReqm(memReqm), .memRdym(memRdym),
        .stallf(stallf), .stalld(stalld), .stalle(stalle), .stallm(stallm),
        .flushd(flushd), .flushe(flushe), .flushw(flushw),
        .fwdAe(fwdAe), .fwdBe(fwdBe), .memTmo(memTmo)
    );

`ifdef FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    // {stallf,stalld,stalle,stallm, flushd,flushe,flushw, fwdAe, fwdBe, memTmo}
    localparam logic [11:0] E0 = 12'b0000_000_00_00_0;
    localparam logic [11:0] MS = 12'b1111_001_00_00_0;
    localparam logic [11:0] LU = 12'b1100_010_00_00_0;
    localparam logic [11:0] BR = 12'b0000_110_00_00_0;
    localparam logic [11:0] RS = 12'b0000_111_00_00_0;
    localparam logic [11:0] TM = 12'b0000_001_00_00_1;

    typedef struct packed {
        logic       rst;
        logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
        logic       we, wm, ww;
        logic [1:0] rslt;
        logic       pc, req, rdy;
    } vin_t;

    typedef struct {
        string       name;
        vin_t        vin;
        logic [11:0] exp;
    } vec_t;

    typedef struct {
        string       name;
        logic [11:0] exp;
    } sb_t;

    vec_t tbl[14];
    sb_t  sbq[$];
    int   nvec = 0;
    int   nerr = 0;

    wire [11:0] got = {stallf, stalld, stalle, stallm, flushd, flushe, flushw, fwdAe, fwdBe, memTmo};

    function automatic logic [11:0] efwd(input logic [1:0] fa, input logic [1:0] fb);
        return FWD ? {7'b0, fa, fb, 1'b0} : E0;
    endfunction

    function automatic vin_t mkin(input logic [4:0] a1d, input logic [4:0] a2d, input logic [4:0] a1e,
                                  input logic [4:0] a2e, input logic [4:0] dE, input logic [4:0] dM,
                                  input logic [4:0] dW, input logic we, input logic wm, input logic ww,
                                  input logic [1:0] rslt, input logic pc);
        vin_t v;
        v = '0;
        v.rs1d = a1d; v.rs2d = a2d; v.rs1e = a1e; v.rs2e = a2e;
        v.rde = dE; v.rdm = dM; v.rdw = dW;
        v.we = we; v.wm = wm; v.ww = ww; v.rslt = rslt; v.pc = pc;
        return v;
    endfunction

    task automatic apply(input vin_t v);
        rst = v.rst; rs1d = v.rs1d; rs2d = v.rs2d; rs1e = v.rs1e; rs2e = v.rs2e;
        rde = v.rde; rdm = v.rdm; rdw = v.rdw;
        regWrte = v.we; regWrtm = v.wm; regWrtw = v.ww; rsltSrce = v.rslt;
        pcSrce = v.pc; memReqm = v.req; memRdym = v.rdy;
    endtask

    task automatic check();
        sb_t s;
        if (sbq.size() == 0) begin
            nerr++;
            $display("FAIL scoreboard: empty queue, got %b", got);
            return;
        end
        s = sbq.pop_front();
        nvec++;
        if (got !== s.exp) begin
            nerr++;
            $display("FAIL %s: got %b expected %b", s.name, got, s.exp);
        end
    endtask

    task automatic step(input string name, input vin_t v, input logic [11:0] e);
        @(posedge clk);
        #1;
        apply(v);
        sbq.push_back('{name, e});
        @(negedge clk);
        check();
    endtask

    initial begin
        vin_t z, lu_v, v;
        z    = '0;
        lu_v = mkin(5, 0, 0, 0, 5, 0, 0, 1, 0, 0, 2'b01, 0);

        tbl[0]  = '{"idle",          z,                                          E0};
        tbl[1]  = '{"loaduse_rs1",   lu_v,                                       LU};
        tbl[2]  = '{"loaduse_rs2",   mkin(0, 5, 0, 0, 5, 0, 0, 1, 0, 0, 2'b01, 0), LU};
        tbl[3]  = '{"x0_load",       mkin(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2'b01, 0), E0};
        tbl[4]  = '{"alu_dep",       mkin(5, 0, 0, 0, 5, 0, 0, 1, 0, 0, 2'b00, 0), FWD ? E0 : LU};
        tbl[5]  = '{"branch",        mkin(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1), BR};
        tbl[6]  = '{"branch_lu",     mkin(5, 0, 0, 0, 5, 0, 0, 1, 0, 0, 2'b01, 1), BR};
        tbl[7]  = '{"fwd_mem_prio",  mkin(0, 0, 7, 0, 0, 7, 7, 0, 1, 1, 2'b00, 0), efwd(2'b10, 2'b00)};
        tbl[8]  = '{"fwd_wb",        mkin(0, 0, 7, 0, 0, 7, 7, 0, 0, 1, 2'b00, 0), efwd(2'b01, 2'b00)};
        tbl[9]  = '{"fwd_x0",        mkin(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 2'b00, 0), E0};
        tbl[10] = '{"fwd_b_wb",      mkin(0, 0, 0, 7, 0, 0, 7, 0, 0, 1, 2'b00, 0), efwd(2'b00, 2'b01)};
        tbl[11] = '{"fwd_ab",        mkin(0, 0, 3, 4, 0, 3, 4, 0, 1, 1, 2'b00, 0), efwd(2'b10, 2'b01)};
        tbl[12] = '{"mem_dep_dec",   mkin(9, 0, 0, 0, 0, 9, 0, 0, 1, 0, 2'b00, 0), FWD ? E0 : LU};
        tbl[13] = '{"x0_mem",        mkin(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 0), E0};

        v = z;
        v.rst = 1'b1;
        apply(v);
        repeat (2) @(posedge clk);

        v = mkin(5, 0, 7, 0, 5, 7, 0, 1, 1, 0, 2'b01, 1);
        v.rst = 1'b1;
        step("reset_state", v, RS);

        for (int i = 0; i < 14; i++) step(tbl[i].name, tbl[i].vin, tbl[i].exp);

        step("lu_cycle1", lu_v, LU);
        step("lu_cycle2", z, E0);

        v = z; v.req = 1'b1;
        for (int i = 0; i < 4; i++) step("tmo_wait", v, MS);
        step("tmo_pulse", v, TM);
        step("tmo_after", z, E0);

        step("rdy_wait1", v, MS);
        step("rdy_wait2", v, MS);
        v.rdy = 1'b1;
        step("rdy_release", v, E0);
        v.rdy = 1'b0;
        for (int i = 0; i < 4; i++) step("rdy_cnt_reset", v, MS);
        step("rdy_tmo", v, TM);
        step("rdy_after", z, E0);

        v = mkin(5, 0, 0, 0, 5, 0, 0, 1, 0, 0, 2'b01, 1);
        v.req = 1'b1;
        step("mw_br_lu_enter", v, MS);
        step("mw_br_lu_hold", v, MS);
        v.rdy = 1'b1;
        step("mw_br_lu_release", v, BR);
        step("mw_br_lu_after", z, E0);

        v = z; v.req = 1'b1;
        step("rst_mw_wait1", v, MS);
        step("rst_mw_wait2", v, MS);
        v.rst = 1'b1;
        step("rst_mw_reset", v, RS);
        for (int i = 0; i < 5; i++) step("rst_mw_after", z, E0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter: MAX_WAIT, 8, maximum data-memory wait-stall cycles before timeout (range 1..255).
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 rs1d, rs2d  in  5 each  decode-stage source registers.
REQ-005 rs1e, rs2e, rde  in  5 each  execute-stage sources and destination.
REQ-006 regWrte, regWrtm, regWrtw  in  1 each  register-write enable per stage.
REQ-007 rsltSrce  in  2  execute-stage result source; 2'b01 marks a load.
REQ-008 rdm, rdw  in  5 each  memory- and writeback-stage destinations.
REQ-009 pcSrce  in  1  taken branch/jump resolved in execute.
REQ-010 memReqm, memRdym  in  1 each  data-memory access request and ready, memory stage.
REQ-011 stallf, stalld, stalle, stallm  out  1 each  hold the fetch PC, IF/ID, ID/EX and EX/ME registers.
REQ-012 flushd, flushe, flushw  out  1 each  bubble IF/ID, ID/EX and ME/WB.
REQ-013 fwdAe, fwdBe  out  2 each  execute operand select: 00 register file, 01 writeback, 10 memory.
REQ-014 memTmo  out  1  one-cycle pulse on data-memory timeout.

Function
REQ-015 FSM has two states: RUN and MWAIT; stall/flush/forward outputs are combinational from state and inputs.
REQ-016 RUN->MWAIT when memReqm=1 and memRdym=0; in that cycle stallf/d/e/m=1, flushw=1, cnt<=1.
REQ-017 MWAIT with memRdym=0 and cnt<MAX_WAIT: stallf/d/e/m=1, flushw=1, cnt<=cnt+1.
REQ-018 MWAIT with memRdym=1: no stall, flushw=0, ->RUN, cnt<=0.
REQ-019 MWAIT with memRdym=0 and cnt==MAX_WAIT: memTmo=1, no stall, flushw=1, ->RUN, cnt<=0.
REQ-020 Load-use, evaluated in RUN without a memory stall: regWrte=1, rsltSrce=2'b01, rde!=0, and rde equals rs1d or rs2d -> stallf=1, stalld=1, flushe=1 for that cycle.
REQ-021 Branch: pcSrce=1 without a memory stall -> flushd=1, flushe=1; this overrides load-use in the same cycle (stallf=stalld=0).
REQ-022 A memory stall dominates: load-use and pcSrce are ignored while stalled and re-evaluated on the first unstalled cycle.
REQ-023 fwdAe=10 if regWrtm=1, rdm!=0 and rdm==rs1e; else 01 if regWrtw=1, rdw!=0 and rdw==rs1e; else 00; fwdBe is identical with rs2e.
REQ-024 Register x0 never causes a hazard or a forward.

Reset
REQ-025 While rst=1: state=RUN, cnt=0, stall outputs 0, flushd=flushe=flushw=1, fwdAe=fwdBe=00, memTmo=0.
REQ-026 Reset asserted during MWAIT abandons the wait; the first cycle after reset is in RUN with no stall.

Configuration
REQ-027 FWD_EN defined: forwarding per REQ-023.
REQ-028 FWD_EN undefined: fwdAe=fwdBe=00 always. In RUN, stallf=stalld=flushe=1 whenever rs1d or rs2d (non-zero) matches rde with regWrte=1, or matches rdm with regWrtm=1. The register file writes through, so the writeback stage needs no stall.

Structure
REQ-029 Package hazard_pkg holds: the state enum {RUN, MWAIT}, the fwd_sel_t enum {FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10}, and the constant RSLT_MEM=2'b01.
REQ-030 Sub-module fwd_unit (combinational, one operand) is instantiated twice, for A and B.

Verification
REQ-031 Load-use: rsltSrce=01, regWrte=1, rde=5, rs1d=5 -> stallf=stalld=flushe=1 for exactly 1 cycle, then 0.
REQ-032 Forward priority: rdm=rdw=7, both regWrt=1, rs1e=7 -> fwdAe=10; with regWrtm=0 -> fwdAe=01; with rs1e=0 -> fwdAe=00.
REQ-033 Timeout, MAX_WAIT=4: memReqm=1, memRdym=0 held -> 4 cycles with stallm=1, memTmo=1 on the 5th cycle, stalls 0 on that cycle.
REQ-034 Wait with ready: memReqm=1, memRdym asserted on the 3rd cycle -> 2 stall cycles, no memTmo, state RUN.
REQ-035 Simultaneous pcSrce=1 and load-use -> flushd=flushe=1, stalld=0. The same inputs during MWAIT -> only memory stall outputs are asserted.
REQ-036 rst asserted mid-MWAIT -> all flushes=1 and stalls=0; after reset release, memReqm=0 -> no stall and memTmo never pulses.
